// File: rtl/mem_responder_if.sv
// Bus between a CPU-side initiator and the memory responder.
interface mem_responder_if;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        m_req;
  logic        m_wr;
  logic [31:0] data_out;
  logic        m_ack;
  logic        m_err;

  modport master (
    output addr, data_in, m_req, m_wr,
    input  data_out, m_ack, m_err
  );

  modport slave (
    input  addr, data_in, m_req, m_wr,
    output data_out, m_ack, m_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised single-port RAM answering CPU bus requests after a
// configurable number of wait states, mapped at BASE_ADDR.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  logic [31:0]      req_addr_q;
  logic [31:0]      req_wdata_q;
  logic             req_wr_q;

  logic [31:0]      off;
  logic [AW-1:0]    idx;
  logic             err;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             ack_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  // State and wait counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the bus is only sampled while idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.m_req) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES != 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request so the initiator may change the bus afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wr_q    <= 1'b0;
    end else if (accept) begin
      req_addr_q  <= bus.addr;
      req_wdata_q <= bus.data_in;
      req_wr_q    <= bus.m_wr;
    end
  end

  // Window decode; addresses below BASE_ADDR wrap to a large offset
  always_comb begin
    off = req_addr_q - BASE_ADDR;
    idx = off[AW+1:2];
    err = (req_addr_q[1:0] != 2'b00) || ((off >> (AW + 2)) != 32'd0);
  end

  // Response registers: ack/err/read data launch as the ACK state ends
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= (state_q == S_ACK);
      err_q <= (state_q == S_ACK) && err;
      if ((state_q == S_ACK) && !req_wr_q) begin
        rdata_q <= err ? 32'h0000_0000 : mem[idx];
      end
    end
  end

  // RAM write commits on the edge closing the ACK state
  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_ACK) && req_wr_q && !err) begin
      mem[idx] <= req_wdata_q;
    end
  end

  assign bus.m_ack    = ack_q;
  assign bus.m_err    = err_q;
  assign bus.data_out = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (0, 2 and 5 wait states)
// share one driven bus; outputs of the instance under test are selected by sel.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] t_addr, t_wdata;
  logic        t_req, t_wr;

  int          sel = 2;
  logic        o_ack, o_err;
  logic [31:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder_if bus0 ();
  mem_responder_if bus2 ();
  mem_responder_if bus5 ();

  assign bus0.addr = t_addr;  assign bus0.data_in = t_wdata;
  assign bus0.m_req = t_req;  assign bus0.m_wr = t_wr;
  assign bus2.addr = t_addr;  assign bus2.data_in = t_wdata;
  assign bus2.m_req = t_req;  assign bus2.m_wr = t_wr;
  assign bus5.addr = t_addr;  assign bus5.data_in = t_wdata;
  assign bus5.m_req = t_req;  assign bus5.m_wr = t_wr;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));
  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(5), .BASE_ADDR(32'h0)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5.slave));

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      0:       begin o_ack = bus0.m_ack; o_err = bus0.m_err; o_data = bus0.data_out; end
      5:       begin o_ack = bus5.m_ack; o_err = bus5.m_err; o_data = bus5.data_out; end
      default: begin o_ack = bus2.m_ack; o_err = bus2.m_err; o_data = bus2.data_out; end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // m_err must never be raised without m_ack
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (bus2.m_err && !bus2.m_ack) begin
        n_bad++;
        $display("FAIL err_without_ack: got m_err=1 m_ack=0 expected m_err=0");
      end
    end
  end

  // Request already driven; drops m_req after the request edge, waits for ack
  task automatic wait_ack(output int lat, output logic [31:0] rd, output logic err,
                          output logic single);
    lat = -1; rd = '0; err = 1'b0; single = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        t_req   = 1'b0;
        t_addr  = ~t_addr;
        t_wdata = ~t_wdata;
      end
      if (o_ack) begin
        lat = i; rd = o_data; err = o_err;
        break;
      end
    end
    @(negedge clk);
    single = !o_ack;
  endtask

  task automatic txn(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic err,
                     output logic single);
    sel = s;
    @(negedge clk);
    t_req = 1'b1; t_wr = wr; t_addr = a; t_wdata = d;
    wait_ack(lat, rd, err, single);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [14];
  int          lat;
  logic [31:0] rd;
  logic        er, single;
  int          nack;
  int          ack_at [3];
  logic [31:0] ack_dat [3];
  logic        seen;

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0004, 32'h1111_0004, 32'hCAFE_F00D, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
    tbl[4]  = '{1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    tbl[5]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h1111_0004, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_0FFC, 32'h1111_0004, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_0FFC, 1'b0};
    tbl[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1'b1};
    tbl[10] = '{1'b1, 32'h0000_0020, 32'h0BAD_0020, 32'h0000_0000, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_0004, 32'h0000_0002, 32'h0000_0000, 1'b0};
    tbl[13] = '{1'b1, 32'h0000_0008, 32'h0000_0003, 32'h0000_0000, 1'b0};

    // Reset held with a request pending: nothing may respond
    reset = 1'b1; t_req = 1'b1; t_wr = 1'b1; t_addr = 32'h40; t_wdata = 32'h4040_4040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_ack[%0d]", i), 32'(o_ack), 32'd0);
      chk($sformatf("reset_data[%0d]", i), o_data, 32'd0);
      chk($sformatf("reset_ack5[%0d]", i), 32'(bus5.m_ack), 32'd0);
    end
    reset = 1'b0;
    wait_ack(lat, rd, er, single);
    chk("post_reset_lat", 32'(lat), 32'd4);
    chk("post_reset_err", 32'(er), 32'd0);
    chk("post_reset_single", 32'(single), 32'd1);

    // Table: writes, reads, range and alignment errors on the 2-wait-state instance
    for (int v = 0; v < 14; v++) begin
      txn(2, tbl[v].wr, tbl[v].addr, tbl[v].wdata, lat, rd, er, single);
      chk($sformatf("v%0d_lat", v), 32'(lat), 32'd4);
      chk($sformatf("v%0d_err", v), 32'(er), 32'(tbl[v].exp_err));
      chk($sformatf("v%0d_data", v), rd, tbl[v].exp_data);
      chk($sformatf("v%0d_single", v), 32'(single), 32'd1);
    end

    // Latency sweep for 0 and 5 wait states
    repeat (10) @(negedge clk);
    txn(0, 1'b0, 32'h10, 32'h0, lat, rd, er, single);
    chk("ws0_lat", 32'(lat), 32'd2);
    chk("ws0_single", 32'(single), 32'd1);
    chk("ws0_data", rd, 32'hCAFE_F00D);
    repeat (10) @(negedge clk);
    txn(5, 1'b1, 32'h100, 32'h5555_0100, lat, rd, er, single);
    chk("ws5_lat", 32'(lat), 32'd7);
    chk("ws5_single", 32'(single), 32'd1);
    repeat (10) @(negedge clk);

    // Back-to-back reads with m_req held high
    sel = 2;
    @(negedge clk);
    t_req = 1'b1; t_wr = 1'b0; t_addr = 32'h0;
    nack = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (o_ack) begin
        if (nack < 3) begin ack_at[nack] = i; ack_dat[nack] = o_data; end
        nack++;
        t_addr = 32'(nack * 4);
        if (nack == 3) t_req = 1'b0;
      end
    end
    chk("b2b_count", 32'(nack), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b_at[%0d]", k), 32'(ack_at[k]), 32'(4 * (k + 1)));
      chk($sformatf("b2b_data[%0d]", k), ack_dat[k], 32'(k + 1));
    end

    // Reset during WAIT drops the write
    @(negedge clk);
    t_req = 1'b1; t_wr = 1'b1; t_addr = 32'h20; t_wdata = 32'h1234_5678;
    @(negedge clk);
    t_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_ack) seen = 1'b1;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    txn(2, 1'b0, 32'h20, 32'h0, lat, rd, er, single);
    chk("abort_lat", 32'(lat), 32'd4);
    chk("abort_data", rd, 32'h0BAD_0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
